// File: rtl/aes_stream_pkg.sv
// Shared types for the AES streaming front-end: FSM states and the FIFO entry layout.
package aes_stream_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      OUT,
      GAP
   } state_t;

   typedef struct packed {
      logic                 first;
      logic [AES_BLK_W-1:0] data;
      logic [AES_BLK_W-1:0] key;
   } fifo_entry_t;

endpackage

// File: rtl/aes_stream_fifo.sv
// Register FIFO with synchronous reset; head entry is visible on rdata while not empty.
module aes_stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (do_push && !do_pop)
            count_reg <= count_reg + CW'(1);
         else if (!do_push && do_pop)
            count_reg <= count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= wdata;
   end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streaming front-end for AES_top: queues blocks, issues them one at a time with
// optional CBC chaining and a per-block timeout, and returns ciphertext on valid/ready.
module aes_stream_ctrl
   import aes_stream_pkg::*;
#(
   parameter int BLK_W       = AES_BLK_W,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             AES_clk,
   input  logic             AES_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic [BLK_W-1:0] in_key,
   input  logic             in_first,
   input  logic             cfg_cbc,
   input  logic [BLK_W-1:0] cfg_iv,
   output logic             core_en,
   output logic [BLK_W-1:0] core_data,
   output logic [BLK_W-1:0] core_key,
   input  logic             core_valid,
   input  logic [BLK_W-1:0] core_dout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             busy,
   output logic             err_timeout
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t           state_reg, state_next;
   fifo_entry_t      wr_entry, head;
   logic             fifo_full, fifo_empty, pop;
   logic [CW-1:0]    fifo_count;
   logic [BLK_W-1:0] core_data_reg, core_key_reg, out_data_reg, chain_reg, chain_sel;
   logic             chain_valid_reg, cbc_reg, err_timeout_reg, timeout_hit;
   logic [TW-1:0]    wait_reg;

   assign wr_entry = {in_first, in_data, in_key};

   aes_stream_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk   (AES_clk),
      .srst  (AES_rst),
      .push  (in_valid),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A new chain, or one broken by a dropped block, restarts from the IV.
   assign chain_sel   = (head.first || !chain_valid_reg) ? cfg_iv : chain_reg;
   assign timeout_hit = (wait_reg == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      core_en    = 1'b0;
      out_valid  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            core_en = 1'b1;
            if (core_valid)       state_next = OUT;
            else if (timeout_hit) state_next = GAP;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = GAP;
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         state_reg       <= IDLE;
         core_data_reg   <= '0;
         core_key_reg    <= '0;
         out_data_reg    <= '0;
         chain_reg       <= '0;
         chain_valid_reg <= 1'b0;
         cbc_reg         <= 1'b0;
         err_timeout_reg <= 1'b0;
         wait_reg        <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  core_key_reg  <= head.key;
                  core_data_reg <= cfg_cbc ? (head.data ^ chain_sel) : head.data;
                  cbc_reg       <= cfg_cbc;
                  wait_reg      <= '0;
               end
            end
            ISSUE: begin
               // core_valid takes priority over a timeout landing in the same cycle.
               if (core_valid) begin
                  out_data_reg <= core_dout;
                  chain_reg    <= core_dout;
                  if (cbc_reg) chain_valid_reg <= 1'b1;
               end else if (timeout_hit) begin
                  err_timeout_reg <= 1'b1;
                  if (cbc_reg) chain_valid_reg <= 1'b0;
               end else begin
                  wait_reg <= wait_reg + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = !fifo_full;
   assign core_data   = core_data_reg;
   assign core_key    = core_key_reg;
   assign out_data    = out_data_reg;
   assign busy        = (state_reg != IDLE) || (fifo_count != '0);
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Scoreboard bench for aes_stream_ctrl with a behavioural AES-128 core stub.
module tb_aes_stream_ctrl;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 255;

   logic         AES_clk = 1'b0;
   logic         AES_rst;
   logic         in_valid, in_ready, in_first, cfg_cbc;
   logic [127:0] in_data, in_key, cfg_iv;
   logic         core_en, core_valid;
   logic [127:0] core_data, core_key, core_dout;
   logic         out_valid, out_ready, busy, err_timeout;
   logic [127:0] out_data;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_out   = 0;
   bit           dead    = 1'b0;
   int           rdy_mode = 3;
   logic [127:0] exp_q [$];
   logic [127:0] m_chain;
   bit           m_chain_valid = 1'b0;
   logic [7:0]   sbox [256];

   aes_stream_ctrl #(.BLK_W(128), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
      .AES_clk(AES_clk), .AES_rst(AES_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .in_first(in_first), .cfg_cbc(cfg_cbc), .cfg_iv(cfg_iv),
      .core_en(core_en), .core_data(core_data), .core_key(core_key),
      .core_valid(core_valid), .core_dout(core_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 AES_clk = ~AES_clk;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, t, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv;
         t = inv;
         for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         sbox[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Offer one block; on acceptance update the CBC model and queue the expected ciphertext.
   task automatic offer(input logic first, input logic [127:0] d, input logic [127:0] k,
                        input bit drop, input bit use_exp, input logic [127:0] exp_ct,
                        input int max_cyc, output bit acc);
      logic [127:0] x, ct;
      in_valid = 1'b1; in_first = first; in_data = d; in_key = k;
      acc = 1'b0;
      for (int c = 0; c < max_cyc && !acc; c++) begin
         @(negedge AES_clk);
         if (in_ready) acc = 1'b1;
         @(posedge AES_clk); #1;
      end
      in_valid = 1'b0;
      if (acc) begin
         if (drop) begin
            if (cfg_cbc) m_chain_valid = 1'b0;
         end else begin
            x  = cfg_cbc ? (d ^ ((first || !m_chain_valid) ? cfg_iv : m_chain)) : d;
            ct = use_exp ? exp_ct : aes_enc(x, k);
            m_chain = ct;
            if (cfg_cbc) m_chain_valid = 1'b1;
            exp_q.push_back(ct);
         end
      end
   endtask

   task automatic push(input logic first, input logic [127:0] d, input logic [127:0] k,
                       input bit use_exp, input logic [127:0] exp_ct);
      bit acc;
      offer(first, d, k, 1'b0, use_exp, exp_ct, 3000, acc);
      check("push_accepted", 128'(acc), 128'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
         @(negedge AES_clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      check("drain_done", 128'(done), 128'd1);
      @(posedge AES_clk); #1;
   endtask

   // Core stub: random latency while core_en is high, ignorable noise pulses while it is low.
   initial begin
      bit active;
      int rem;
      active = 1'b0; rem = 0;
      core_valid = 1'b0; core_dout = '0;
      forever begin
         @(negedge AES_clk);
         core_valid = 1'b0;
         if (core_en && !dead) begin
            if (!active) begin
               active = 1'b1;
               rem = $urandom_range(0, 3);
            end else begin
               rem = rem - 1;
            end
            if (rem == 0) begin
               core_valid = 1'b1;
               core_dout  = aes_enc(core_data, core_key);
            end
         end else if (!core_en) begin
            active = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
               core_valid = 1'b1;
               core_dout  = rnd128();
            end
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge AES_clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = ~out_ready;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks output stability while stalled.
   initial begin
      bit           hold;
      logic [127:0] hold_data, e;
      hold = 1'b0; hold_data = '0;
      forever begin
         @(negedge AES_clk);
         if (AES_rst) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("out_valid_held", 128'(out_valid), 128'd1);
               check("out_data_stable", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", out_data, 128'hx);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", out_data, e);
                  $display("[TB] out %0d: %h", n_out, out_data);
                  n_out++;
               end
               hold = 1'b0;
            end else if (out_valid) begin
               hold = 1'b1;
               hold_data = out_data;
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n_acc, cnt;
      logic [127:0] k0;
      build_sbox();
      AES_rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; in_key = '0;
      cfg_cbc = 1'b0; cfg_iv = '0; rdy_mode = 3;
      repeat (3) @(posedge AES_clk);
      #1 AES_rst = 1'b0;
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_core_en", 128'(core_en), 128'd0);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_err_timeout", 128'(err_timeout), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_core_data", core_data, 128'd0);
      check("rst_core_key", core_key, 128'd0);

      // FIPS-197 ECB vector
      cfg_cbc = 1'b0;
      push(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      drain();

      // SP800-38A CBC, two chained blocks
      cfg_cbc = 1'b1; cfg_iv = 128'h000102030405060708090a0b0c0d0e0f;
      k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      push(1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, k0, 1'b1, 128'h7649abac8119b246cee98e9b12e9197d);
      push(1'b0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, k0, 1'b1, 128'h5086cb9b507219ee95db113a917678b2);
      drain();

      // Back-pressure: one block in flight plus DEPTH queued, then the FIFO refuses
      rdy_mode = 0; cfg_cbc = 1'b0; n_acc = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         offer(1'b0, rnd128(), rnd128(), 1'b0, 1'b0, '0, 30, acc);
         if (acc) n_acc++;
      end
      check("fill_accepted", 128'(n_acc), 128'(DEPTH + 1));
      offer(1'b0, 128'h5a5a, 128'ha5a5, 1'b0, 1'b0, '0, 20, acc);
      check("full_rejects", 128'(acc), 128'd0);
      check("full_in_ready", 128'(in_ready), 128'd0);
      check("full_busy", 128'(busy), 128'd1);
      check("full_out_valid", 128'(out_valid), 128'd1);
      rdy_mode = 1;
      push(1'b0, 128'h5a5a, 128'ha5a5, 1'b0, '0);
      drain();

      // out_ready toggling every cycle on a CBC chain
      rdy_mode = 2; cfg_cbc = 1'b1; cfg_iv = rnd128();
      for (int i = 0; i < 8; i++) push(1'(i == 0), rnd128(), rnd128(), 1'b0, '0);
      drain();

      // Random phases with random mode, IV, chain starts and gaps
      rdy_mode = 1;
      for (int ph = 0; ph < 3; ph++) begin
         cfg_cbc = 1'($urandom_range(0, 1)); cfg_iv = rnd128();
         for (int i = 0; i < 12; i++) begin
            push(1'($urandom_range(0, 3) == 0), rnd128(), rnd128(), 1'b0, '0);
            repeat ($urandom_range(0, 2)) begin @(posedge AES_clk); #1; end
         end
         drain();
      end

      // Core never answers: block dropped after TIMEOUT cycles, chain restarts from IV
      rdy_mode = 3; cfg_cbc = 1'b1; cfg_iv = rnd128(); dead = 1'b1;
      offer(1'b0, rnd128(), rnd128(), 1'b1, 1'b0, '0, 100, acc);
      check("dead_accepted", 128'(acc), 128'd1);
      cnt = 0;
      for (int c = 0; c < 20 && !core_en; c++) @(negedge AES_clk);
      while (core_en && cnt < 2000) begin
         cnt++;
         @(negedge AES_clk);
      end
      check("timeout_core_en_len", 128'(cnt), 128'(TIMEOUT));
      @(posedge AES_clk); #1;
      check("err_timeout_set", 128'(err_timeout), 128'd1);
      dead = 1'b0;
      push(1'b0, rnd128(), rnd128(), 1'b0, '0);
      drain();
      check("err_timeout_sticky", 128'(err_timeout), 128'd1);

      // Reset while ISSUE is stuck on a silent core with another block queued
      dead = 1'b1;
      offer(1'b0, rnd128(), rnd128(), 1'b1, 1'b0, '0, 100, acc);
      offer(1'b0, rnd128(), rnd128(), 1'b1, 1'b0, '0, 100, acc);
      for (int c = 0; c < 20 && !core_en; c++) @(negedge AES_clk);
      check("issue_before_rst", 128'(core_en), 128'd1);
      @(posedge AES_clk); #1 AES_rst = 1'b1;
      @(posedge AES_clk); #1 AES_rst = 1'b0;
      exp_q.delete(); m_chain_valid = 1'b0; dead = 1'b0;
      check("mid_rst_core_en", 128'(core_en), 128'd0);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_err_timeout", 128'(err_timeout), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      repeat (3) begin @(posedge AES_clk); #1; end
      check("fifo_flushed", 128'(core_en), 128'd0);
      cfg_cbc = 1'b1; cfg_iv = rnd128();
      push(1'b0, rnd128(), rnd128(), 1'b0, '0);
      drain();

      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
